// File: rtl/key_debounce_multi_pkg.sv
// Shared definitions for the multi-channel key conditioner: hold-FSM state
// encoding, idle-level helper and counter-width helper.
package key_debounce_multi_pkg;

    // Hold-FSM states, one FSM per key channel.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } hold_state_t;

    localparam int STATE_W = 2;

    // Level a key rests at when not pressed: high for active-low keys.
    function automatic logic idle_level(input logic active_low);
        return active_low;
    endfunction

    // Width able to hold every count up to value; the +1 bit keeps headroom
    // and gives a legal 1-bit counter when value is 0 or 1.
    function automatic int cnt_width(input int value);
        return $clog2(value) + 1;
    endfunction

endpackage

// File: rtl/key_debounce_multi_ch.sv
// One key channel: two-flop synchroniser, stable-window debouncer and the
// hold FSM that produces long-press and auto-repeat pulses.
//
// Handshake note: there is no valid/ready flow here. Every pulse output is a
// registered single-cycle strobe; consumers sample it on the clock edge after
// it rises and must not expect it to be held.
module key_debounce_ch
    import key_debounce_multi_pkg::*;
#(
    parameter int DB_CYCLES      = 1000000,
    parameter int LONG_CYCLES    = 50000000,
    parameter int REPEAT_CYCLES  = 10000000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               key,
    output logic               key_value,
    output logic               key_flag,
    output logic               key_press,
    output logic               key_release,
    output logic               key_long,
    output logic               key_repeat,
    output logic [STATE_W-1:0] hold_state
);

    localparam logic IDLE_LVL = idle_level(KEY_ACTIVE_LOW);

    // Debounce counter runs 0 .. DB_CYCLES-1 and clears at the terminal value.
    localparam int              DB_W    = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DB_CYCLES - 1);

    // One hold counter serves both the long-press and the repeat interval.
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);
    localparam int LONG_T   = (LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0;
    localparam int REP_T    = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_T);
    localparam logic [HOLD_W-1:0] REP_TERM  = HOLD_W'(REP_T);

    logic [1:0]        sync_q;
    logic              sync_lvl;
    logic [DB_W-1:0]   db_cnt;
    logic              differ;
    logic              accept;
    logic              press_evt;
    logic              release_evt;
    hold_state_t       state;
    logic [HOLD_W-1:0] hold_cnt;

    // Two-flop synchroniser; resets to the idle level so reset is never a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= {2{IDLE_LVL}};
        end else begin
            sync_q <= {sync_q[0], key};
        end
    end

    assign sync_lvl = sync_q[1];

    // A change is accepted only after the synced level has differed from the
    // debounced level for DB_CYCLES consecutive cycles.
    assign differ      = (sync_lvl != key_value);
    assign accept      = differ && (db_cnt == DB_TERM);
    assign press_evt   = accept && (sync_lvl != IDLE_LVL);
    assign release_evt = accept && (sync_lvl == IDLE_LVL);

    // Debounce counter, debounced level and change/press/release strobes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            db_cnt      <= '0;
            key_value   <= IDLE_LVL;
            key_flag    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_flag    <= accept;
            key_press   <= press_evt;
            key_release <= release_evt;
            if (!differ || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (accept) begin
                key_value <= sync_lvl;
            end
        end
    end

    // Hold FSM: a release forces IDLE from any state and suppresses any
    // long/repeat strobe that would otherwise land in the same cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            key_long   <= 1'b0;
            key_repeat <= 1'b0;
        end else begin
            key_long   <= 1'b0;
            key_repeat <= 1'b0;
            if (release_evt) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press_evt) begin
                            state    <= ST_PRESSED;
                            hold_cnt <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        // With long-press disabled the counter stays parked at 0.
                        if (LONG_CYCLES != 0) begin
                            if (hold_cnt == LONG_TERM) begin
                                state    <= ST_LONG;
                                hold_cnt <= '0;
                                key_long <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    ST_LONG: begin
                        // With repeat disabled LONG simply waits for release.
                        if (REPEAT_CYCLES != 0) begin
                            if (hold_cnt == REP_TERM) begin
                                hold_cnt   <= '0;
                                key_repeat <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign hold_state = state;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel key conditioner: NUM_KEYS independent copies of
// key_debounce_ch, outputs gathered bit-per-channel. hold_state carries each
// channel's hold-FSM state, two bits per channel, channel 0 in the LSBs.
module key_debounce_multi
    import key_debounce_multi_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int DB_CYCLES      = 1000000,
    parameter int LONG_CYCLES    = 50000000,
    parameter int REPEAT_CYCLES  = 10000000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [NUM_KEYS-1:0]         key,
    output logic [NUM_KEYS-1:0]         key_value,
    output logic [NUM_KEYS-1:0]         key_flag,
    output logic [NUM_KEYS-1:0]         key_press,
    output logic [NUM_KEYS-1:0]         key_release,
    output logic [NUM_KEYS-1:0]         key_long,
    output logic [NUM_KEYS-1:0]         key_repeat,
    output logic [STATE_W*NUM_KEYS-1:0] hold_state
);

    // One fully independent conditioner per key pin.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES      (DB_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key         (key[i]),
            .key_value   (key_value[i]),
            .key_flag    (key_flag[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i]),
            .hold_state  (hold_state[STATE_W*i +: STATE_W])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: a main instance (long/repeat enabled) and a
// second instance with long-press disabled share the same key stimulus.
module tb_key_debounce_multi;

  localparam int NK   = 4;
  localparam int DB   = 8;
  localparam int LONG = 40;
  localparam int REP  = 10;
  localparam logic [NK-1:0] IDLE = 4'hF;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic [NK-1:0] key;
  int cyc = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [NK-1:0]   key_value, key_flag, key_press, key_release, key_long, key_repeat;
  logic [2*NK-1:0] hold_state;
  logic [NK-1:0]   nl_value, nl_flag, nl_press, nl_release, nl_long, nl_repeat;
  logic [2*NK-1:0] nl_state;

  key_debounce_multi #(
    .NUM_KEYS(NK), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
    .key_value(key_value), .key_flag(key_flag), .key_press(key_press),
    .key_release(key_release), .key_long(key_long), .key_repeat(key_repeat),
    .hold_state(hold_state)
  );

  key_debounce_multi #(
    .NUM_KEYS(NK), .DB_CYCLES(DB), .LONG_CYCLES(0), .REPEAT_CYCLES(REP), .KEY_ACTIVE_LOW(1'b1)
  ) dut_nl (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key),
    .key_value(nl_value), .key_flag(nl_flag), .key_press(nl_press),
    .key_release(nl_release), .key_long(nl_long), .key_repeat(nl_repeat),
    .hold_state(nl_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is the raw key level seen just before the next edge; the level the
  // conditioner acts on at that edge is two samples older (synchroniser).
  logic [NK-1:0]   hist[$];
  logic [NK-1:0]   m_value, m_flag, m_press, m_release, m_long, m_rep, m_long_nl, m_rep_nl;
  logic [2*NK-1:0] m_state, m_state_nl;
  bit              held[NK];
  int              pt[NK];

  // Long/repeat expectations from the time d elapsed since the press pulse.
  task automatic hold_model(input bit h, input int d, input int lp, input int rp, input bit evt,
                            output logic lg, output logic rpt, output logic [1:0] st);
    lg  = 1'b0;
    rpt = 1'b0;
    st  = h ? 2'd1 : 2'd0;
    if (h && lp > 0 && d >= lp) st = 2'd2;
    if (h && !evt && lp > 0) begin
      lg  = (d == lp);
      rpt = (rp > 0) && (d > lp) && ((d - lp) % rp == 0);
    end
  endtask

  task automatic model_reset();
    m_value = IDLE;
    m_flag = '0; m_press = '0; m_release = '0; m_long = '0; m_rep = '0;
    m_long_nl = '0; m_rep_nl = '0; m_state = '0; m_state_nl = '0;
    for (int c = 0; c < NK; c++) begin held[c] = 1'b0; pt[c] = 0; end
    hist.delete();
    for (int j = 0; j < DB + 2; j++) hist.push_back(IDLE);
  endtask

  task automatic model_step();
    int idx;
    bit all_diff;
    logic lg, rpt;
    logic [1:0] st;
    idx = cyc + 1;
    for (int c = 0; c < NK; c++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (hist[j][c] == m_value[c]) all_diff = 1'b0;
      m_flag[c]    = all_diff;
      m_press[c]   = all_diff && m_value[c];
      m_release[c] = all_diff && !m_value[c];
      if (all_diff) m_value[c] = ~m_value[c];
      if (m_press[c]) begin held[c] = 1'b1; pt[c] = idx; end
      if (m_release[c]) held[c] = 1'b0;
      hold_model(held[c], idx - pt[c], LONG, REP, all_diff, lg, rpt, st);
      m_long[c] = lg; m_rep[c] = rpt; m_state[2*c +: 2] = st;
      hold_model(held[c], idx - pt[c], 0, REP, all_diff, lg, rpt, st);
      m_long_nl[c] = lg; m_rep_nl[c] = rpt; m_state_nl[2*c +: 2] = st;
    end
  endtask

  // Single compare process: checks every cycle, then advances the model.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) model_reset();
    check("key_value", key_value, m_value);
    check("key_flag", key_flag, m_flag);
    check("key_press", key_press, m_press);
    check("key_release", key_release, m_release);
    check("key_long", key_long, m_long);
    check("key_repeat", key_repeat, m_rep);
    check("hold_state", hold_state, m_state);
    check("nl_value", nl_value, m_value);
    check("nl_flag", nl_flag, m_flag);
    check("nl_press", nl_press, m_press);
    check("nl_release", nl_release, m_release);
    check("nl_long", nl_long, m_long_nl);
    check("nl_repeat", nl_repeat, m_rep_nl);
    check("nl_state", nl_state, m_state_nl);
    hist.push_front(sys_rst_n ? key : IDLE);
    if (hist.size() > DB + 2) void'(hist.pop_back());
    if (sys_rst_n) model_step();
  end

  // ---------------- event monitor for literal timing checks ----------------
  int last_press[NK], last_long[NK], last_rel[NK], press_cnt[NK], long_cnt[NK];
  int rep2_q[$];
  int nl_pulse_cnt = 0;

  always @(negedge sys_clk) begin
    for (int c = 0; c < NK; c++) begin
      if (key_press[c])   begin last_press[c] = cyc; press_cnt[c]++; end
      if (key_long[c])    begin last_long[c] = cyc; long_cnt[c]++; end
      if (key_release[c]) last_rel[c] = cyc;
      if (nl_long[c] || nl_repeat[c]) nl_pulse_cnt++;
    end
    if (key_repeat[2]) rep2_q.push_back(cyc);
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int t0, p, tr, ts;
    sys_rst_n = 1'b0;
    key = IDLE;
    for (int c = 0; c < NK; c++) begin
      last_press[c] = -1; last_long[c] = -1; last_rel[c] = -1; press_cnt[c] = 0; long_cnt[c] = 0;
    end
    tick(3);
    sys_rst_n = 1'b1;
    tick(2);
    check("reset key_value", key_value, 32'hF);
    check("reset pulses", key_flag | key_press | key_release | key_long | key_repeat, 32'h0);

    // First press on channel 0, kept held long enough for the disable case.
    key[0] = 1'b0;
    t0 = cyc;
    tick(12);
    check("press0 latency", last_press[0] - t0, 32'd10);
    check("press0 key_value", key_value, 32'hE);
    tick(200);
    check("no long when disabled", nl_pulse_cnt, 32'd0);
    check("long0 count", long_cnt[0], 32'd1);
    check("long0 latency", last_long[0] - last_press[0], 32'd40);
    key[0] = 1'b1;
    tick(20);

    // Bounce: short low bursts never get accepted.
    repeat (4) begin
      key[1] = 1'b0; tick(5);
      key[1] = 1'b1; tick(5);
    end
    tick(15);
    check("bounce press count", press_cnt[1], 32'd0);
    check("bounce key_value", key_value[1], 32'd1);

    // Long press and repeat on channel 2, released 80 cycles after the press.
    key[2] = 1'b0;
    tick(12);
    p = last_press[2];
    tick(p + 80 - cyc);
    key[2] = 1'b1;
    tr = cyc;
    tick(25);
    check("long2 latency", last_long[2] - p, 32'd40);
    check("repeat2 count", rep2_q.size(), 32'd4);
    if (rep2_q.size() >= 3) begin
      check("repeat2 first", rep2_q[0] - last_long[2], 32'd10);
      check("repeat2 second", rep2_q[1] - last_long[2], 32'd20);
      check("repeat2 third", rep2_q[2] - last_long[2], 32'd30);
    end
    check("release2 latency", last_rel[2] - tr, 32'd10);

    // All keys fall on the same edge.
    key = 4'h0;
    ts = cyc;
    tick(12);
    for (int c = 0; c < NK; c++) check("simultaneous press", last_press[c] - ts, 32'd10);
    key = IDLE;
    tick(15);

    // Keys fall one cycle apart.
    ts = cyc;
    for (int c = 0; c < NK; c++) begin key[c] = 1'b0; tick(1); end
    tick(12);
    for (int c = 0; c < NK; c++) check("staggered press", last_press[c] - ts, 10 + c);

    // Reset while channel 3 is in LONG; key stays down through reset.
    tick(40);
    check("ch3 in long", hold_state[7:6], 32'd2);
    sys_rst_n = 1'b0;
    #1;
    check("async reset key_value", key_value, 32'hF);
    check("async reset state", hold_state, 32'h0);
    check("async reset pulses", key_flag | key_press | key_long | key_repeat, 32'h0);
    tick(3);
    sys_rst_n = 1'b1;
    tr = cyc;
    tick(12);
    check("press after reset", last_press[3] - tr, 32'd10);
    key = IDLE;
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
